// File: rtl/dice_game_gen_if.sv
// Player-facing signal bundle of the craps controller: button, new-game request, dice sum in;
// dice-counter enable, result flags, point and statistics out.
interface dice_game_gen_if #(
  parameter int SUM_W = 4,
  parameter int CNT_W = 8
);
  logic             Rb_i;
  logic             Reset_i;
  logic [SUM_W-1:0] sum_i;
  logic             roll_o;
  logic             win_o;
  logic             lose_o;
  logic [SUM_W-1:0] point_o;
  logic             point_valid_o;
  logic [CNT_W-1:0] roll_cnt_o;
  logic [CNT_W-1:0] wins_o;
  logic [CNT_W-1:0] losses_o;

  // Player / stimulus side
  modport master (
    output Rb_i, Reset_i, sum_i,
    input  roll_o, win_o, lose_o, point_o, point_valid_o, roll_cnt_o, wins_o, losses_o
  );

  // Controller side
  modport slave (
    input  Rb_i, Reset_i, sum_i,
    output roll_o, win_o, lose_o, point_o, point_valid_o, roll_cnt_o, wins_o, losses_o
  );
endinterface

// File: rtl/dice_game_gen.sv
// Parametrised craps controller: drives the dice counter, resolves first roll and point rolls,
// tracks the point, the per-game roll count and saturating win/loss statistics.
module dice_game_gen #(
  parameter int FACES     = 6,
  parameter int SUM_W     = 4,
  parameter int MAX_ROLLS = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  dice_game_gen_if.slave   bus
);

  localparam logic [SUM_W-1:0] SUM_MIN    = SUM_W'(2);
  localparam logic [SUM_W-1:0] SUM_MAX    = SUM_W'(2 * FACES);
  localparam logic [SUM_W-1:0] NAT1       = SUM_W'(FACES + 1);
  localparam logic [SUM_W-1:0] NAT2       = SUM_W'(2 * FACES - 1);
  localparam logic [SUM_W-1:0] CRAPS3     = SUM_W'(3);
  localparam logic [CNT_W-1:0] ROLL_LIMIT = CNT_W'(MAX_ROLLS);
  localparam bit               LIMIT_EN   = (MAX_ROLLS != 0);

  typedef enum logic [2:0] {
    WAIT_FIRST,
    ROLL_FIRST,
    EVAL_FIRST,
    WAIT_NEXT,
    ROLL_NEXT,
    EVAL_NEXT,
    WIN,
    LOSE
  } state_t;

  state_t           state_q, state_d;
  logic             roll_q, roll_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;
  logic [SUM_W-1:0] point_q, point_d;
  logic             point_valid_q, point_valid_d;
  logic [CNT_W-1:0] roll_cnt_q, roll_cnt_d;
  logic [CNT_W-1:0] wins_q, wins_d;
  logic [CNT_W-1:0] losses_q, losses_d;

  logic             sum_legal;
  logic             sum_natural;
  logic             sum_craps;
  logic [CNT_W-1:0] roll_cnt_inc;

  always_comb begin
    sum_legal    = (bus.sum_i >= SUM_MIN) && (bus.sum_i <= SUM_MAX);
    sum_natural  = (bus.sum_i == NAT1) || (bus.sum_i == NAT2);
    sum_craps    = (bus.sum_i == SUM_MIN) || (bus.sum_i == CRAPS3) || (bus.sum_i == SUM_MAX);
    roll_cnt_inc = (roll_cnt_q == '1) ? roll_cnt_q : roll_cnt_q + CNT_W'(1);

    state_d       = state_q;
    point_d       = point_q;
    point_valid_d = point_valid_q;
    roll_cnt_d    = roll_cnt_q;

    // A new-game request overrides everything, including a roll in progress.
    if (bus.Reset_i) begin
      state_d       = WAIT_FIRST;
      point_d       = '0;
      point_valid_d = 1'b0;
      roll_cnt_d    = '0;
    end else begin
      case (state_q)
        WAIT_FIRST: if (bus.Rb_i)  state_d = ROLL_FIRST;
        ROLL_FIRST: if (!bus.Rb_i) state_d = EVAL_FIRST;
        EVAL_FIRST: begin
          if (!sum_legal) begin
            state_d = WAIT_FIRST;
          end else begin
            roll_cnt_d = roll_cnt_inc;
            if (sum_natural) begin
              state_d = WIN;
            end else if (sum_craps) begin
              state_d = LOSE;
            end else begin
              point_d       = bus.sum_i;
              point_valid_d = 1'b1;
              state_d       = WAIT_NEXT;
            end
          end
        end
        WAIT_NEXT: if (bus.Rb_i)  state_d = ROLL_NEXT;
        ROLL_NEXT: if (!bus.Rb_i) state_d = EVAL_NEXT;
        EVAL_NEXT: begin
          if (!sum_legal) begin
            state_d = WAIT_NEXT;
          end else begin
            roll_cnt_d = roll_cnt_inc;
            // Making the point beats both a seven-out and the roll limit.
            if (bus.sum_i == point_q) begin
              state_d = WIN;
            end else if (bus.sum_i == NAT1) begin
              state_d = LOSE;
            end else if (LIMIT_EN && (roll_cnt_inc == ROLL_LIMIT)) begin
              state_d = LOSE;
            end else begin
              state_d = WAIT_NEXT;
            end
          end
        end
        WIN:     state_d = WIN;
        LOSE:    state_d = LOSE;
        default: state_d = WAIT_FIRST;
      endcase
    end

    // Outputs are decoded from the next state so they register together with it.
    roll_d = (state_d == ROLL_FIRST) || (state_d == ROLL_NEXT);
    win_d  = (state_d == WIN);
    lose_d = (state_d == LOSE);

    wins_d   = wins_q;
    losses_d = losses_q;
    if ((state_d == WIN) && (state_q != WIN) && (wins_q != '1)) begin
      wins_d = wins_q + CNT_W'(1);
    end
    if ((state_d == LOSE) && (state_q != LOSE) && (losses_q != '1)) begin
      losses_d = losses_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_FIRST;
      roll_q        <= 1'b0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      point_q       <= '0;
      point_valid_q <= 1'b0;
      roll_cnt_q    <= '0;
      wins_q        <= '0;
      losses_q      <= '0;
    end else begin
      state_q       <= state_d;
      roll_q        <= roll_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
      point_q       <= point_d;
      point_valid_q <= point_valid_d;
      roll_cnt_q    <= roll_cnt_d;
      wins_q        <= wins_d;
      losses_q      <= losses_d;
    end
  end

  assign bus.roll_o        = roll_q;
  assign bus.win_o         = win_q;
  assign bus.lose_o        = lose_q;
  assign bus.point_o       = point_q;
  assign bus.point_valid_o = point_valid_q;
  assign bus.roll_cnt_o    = roll_cnt_q;
  assign bus.wins_o        = wins_q;
  assign bus.losses_o      = losses_q;

endmodule

// File: tb/tb_dice_game_gen.sv
// Bench for dice_game_gen: default, roll-limited and narrow-counter instances share one stimulus
// stream; each phase checks only the instance it targets.
module tb_dice_game_gen;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       rb    = 1'b0;
  logic       rst_i = 1'b0;
  logic [3:0] sum   = 4'd0;

  always #5 clk = ~clk;

  dice_game_gen_if #(.SUM_W(4), .CNT_W(8)) if_def ();
  dice_game_gen_if #(.SUM_W(4), .CNT_W(8)) if_lim ();
  dice_game_gen_if #(.SUM_W(4), .CNT_W(2)) if_sat ();

  assign if_def.Rb_i = rb;  assign if_def.Reset_i = rst_i;  assign if_def.sum_i = sum;
  assign if_lim.Rb_i = rb;  assign if_lim.Reset_i = rst_i;  assign if_lim.sum_i = sum;
  assign if_sat.Rb_i = rb;  assign if_sat.Reset_i = rst_i;  assign if_sat.sum_i = sum;

  dice_game_gen #(.FACES(6), .SUM_W(4), .MAX_ROLLS(0), .CNT_W(8)) u_def (
    .clk(clk), .rst_n(rst_n), .bus(if_def));
  dice_game_gen #(.FACES(6), .SUM_W(4), .MAX_ROLLS(3), .CNT_W(8)) u_lim (
    .clk(clk), .rst_n(rst_n), .bus(if_lim));
  dice_game_gen #(.FACES(6), .SUM_W(4), .MAX_ROLLS(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(if_sat));

  typedef struct {
    int dut;
    int sum;
    int abort;
    int win;
    int lose;
    int point;
    int pv;
    int cnt;
    int wins;
    int losses;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input int d, input int s, input int ab, input int w, input int l,
                     input int p, input int pv, input int c, input int ws, input int ls);
    vec_t v;
    v.dut = d; v.sum = s; v.abort = ab; v.win = w; v.lose = l;
    v.point = p; v.pv = pv; v.cnt = c; v.wins = ws; v.losses = ls;
    vecs.push_back(v);
  endtask

  task automatic sample(input int dut, output vec_t a);
    a.dut    = dut;
    a.sum    = 0;
    a.abort  = 0;
    a.win    = (dut == 0) ? int'(if_def.win_o)         : int'(if_lim.win_o);
    a.lose   = (dut == 0) ? int'(if_def.lose_o)        : int'(if_lim.lose_o);
    a.point  = (dut == 0) ? int'(if_def.point_o)       : int'(if_lim.point_o);
    a.pv     = (dut == 0) ? int'(if_def.point_valid_o) : int'(if_lim.point_valid_o);
    a.cnt    = (dut == 0) ? int'(if_def.roll_cnt_o)    : int'(if_lim.roll_cnt_o);
    a.wins   = (dut == 0) ? int'(if_def.wins_o)        : int'(if_lim.wins_o);
    a.losses = (dut == 0) ? int'(if_def.losses_o)      : int'(if_lim.losses_o);
  endtask

  task automatic compare(input string tag, input vec_t a, input vec_t e);
    chk({tag, ".win"},    a.win,    e.win);
    chk({tag, ".lose"},   a.lose,   e.lose);
    chk({tag, ".point"},  a.point,  e.point);
    chk({tag, ".pvalid"}, a.pv,     e.pv);
    chk({tag, ".rolls"},  a.cnt,    e.cnt);
    chk({tag, ".wins"},   a.wins,   e.wins);
    chk({tag, ".losses"}, a.losses, e.losses);
  endtask

  // Press for 'hold' cycles, release with the sum presented; returns one cycle after EVAL.
  task automatic do_roll(input int s, input int hold);
    rb = 1'b1;
    repeat (hold) tick();
    rb  = 1'b0;
    sum = 4'(s);
    tick();
    tick();
  endtask

  task automatic pulse_rst_n();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic new_game();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t a;
    vec_t e;
    int   prev_dut;

    // Default instance; stats start at wins=1 after the opening hand sequence.
    add(0, 12, 1, 0, 1,  0, 0, 1, 1, 1);
    add(0,  4, 0, 0, 0,  4, 1, 1, 1, 1);
    add(0,  5, 0, 0, 0,  4, 1, 2, 1, 1);
    add(0,  8, 0, 0, 0,  4, 1, 3, 1, 1);
    add(0,  4, 1, 1, 0,  4, 1, 4, 2, 1);
    add(0,  6, 0, 0, 0,  6, 1, 1, 2, 1);
    add(0,  7, 1, 0, 1,  6, 1, 2, 2, 2);
    add(0,  0, 0, 0, 0,  0, 0, 0, 2, 2);
    add(0, 13, 0, 0, 0,  0, 0, 0, 2, 2);
    add(0, 11, 1, 1, 0,  0, 0, 1, 3, 2);
    add(0,  2, 1, 0, 1,  0, 0, 1, 3, 3);
    add(0,  3, 1, 0, 1,  0, 0, 1, 3, 4);
    add(0, 10, 0, 0, 0, 10, 1, 1, 3, 4);
    add(0, 15, 0, 0, 0, 10, 1, 1, 3, 4);
    add(0, 10, 1, 1, 0, 10, 1, 2, 4, 4);
    add(0,  9, 0, 0, 0,  9, 1, 1, 4, 4);
    add(0, 12, 0, 0, 0,  9, 1, 2, 4, 4);
    add(0, 11, 0, 0, 0,  9, 1, 3, 4, 4);
    add(0,  9, 1, 1, 0,  9, 1, 4, 5, 4);
    // Roll-limited instance (MAX_ROLLS=3), fresh after rst_n.
    add(1,  5, 0, 0, 0,  5, 1, 1, 0, 0);
    add(1,  8, 0, 0, 0,  5, 1, 2, 0, 0);
    add(1,  9, 1, 0, 1,  5, 1, 3, 0, 1);
    add(1,  5, 0, 0, 0,  5, 1, 1, 0, 1);
    add(1,  0, 0, 0, 0,  5, 1, 1, 0, 1);
    add(1,  8, 0, 0, 0,  5, 1, 2, 0, 1);
    add(1,  9, 1, 0, 1,  5, 1, 3, 0, 2);
    add(1,  6, 0, 0, 0,  6, 1, 1, 0, 2);
    add(1,  8, 0, 0, 0,  6, 1, 2, 0, 2);
    add(1,  6, 1, 1, 0,  6, 1, 3, 1, 2);

    // Power-on reset
    #2 rst_n = 1'b0;
    #1;
    chk("reset.roll", int'(if_def.roll_o), 0);
    chk("reset.win",  int'(if_def.win_o),  0);
    chk("reset.lose", int'(if_def.lose_o), 0);
    chk("reset.point", int'(if_def.point_o), 0);
    chk("reset.rolls", int'(if_def.roll_cnt_o), 0);
    chk("reset.wins",  int'(if_def.wins_o), 0);
    chk("reset.lim_losses", int'(if_lim.losses_o), 0);
    chk("reset.sat_wins", int'(if_sat.wins_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Natural on the first roll with a 3-cycle press
    rb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("nat7.roll_hi%0d", k), int'(if_def.roll_o), 1);
    end
    rb  = 1'b0;
    sum = 4'd7;
    tick();
    chk("nat7.eval_roll", int'(if_def.roll_o), 0);
    chk("nat7.eval_win",  int'(if_def.win_o),  0);
    tick();
    chk("nat7.win",   int'(if_def.win_o),      1);
    chk("nat7.lose",  int'(if_def.lose_o),     0);
    chk("nat7.wins",  int'(if_def.wins_o),     1);
    chk("nat7.rolls", int'(if_def.roll_cnt_o), 1);
    $display("txn nat7: win=%0d wins=%0d rolls=%0d", if_def.win_o, if_def.wins_o, if_def.roll_cnt_o);
    rb = 1'b1;
    tick();
    chk("win.rb_ignored", int'(if_def.roll_o), 0);
    chk("win.held",       int'(if_def.win_o),  1);
    chk("win.wins_once",  int'(if_def.wins_o), 1);
    rb = 1'b0;
    new_game();
    chk("newgame.win",   int'(if_def.win_o),      0);
    chk("newgame.rolls", int'(if_def.roll_cnt_o), 0);
    chk("newgame.wins",  int'(if_def.wins_o),     1);

    // Table vectors through the scoreboard
    prev_dut = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].dut != prev_dut) pulse_rst_n();
      prev_dut = vecs[i].dut;
      sb.push_back(vecs[i]);
      do_roll(vecs[i].sum, 1 + (i % 3));
      sample(vecs[i].dut, a);
      if (sb.size() == 0) begin
        chk($sformatf("vec%0d.sb_empty", i), 1, 0);
      end else begin
        e = sb.pop_front();
        compare($sformatf("vec%0d", i), a, e);
      end
      $display("txn vec%0d dut=%0d sum=%0d win=%0d lose=%0d point=%0d rolls=%0d wins=%0d losses=%0d",
               i, vecs[i].dut, vecs[i].sum, a.win, a.lose, a.point, a.cnt, a.wins, a.losses);
      if (vecs[i].abort != 0) begin
        new_game();
        sample(vecs[i].dut, a);
        e = vecs[i];
        e.win = 0; e.lose = 0; e.point = 0; e.pv = 0; e.cnt = 0;
        compare($sformatf("vec%0d.newgame", i), a, e);
      end
    end

    // New-game request together with the button while a point is held
    pulse_rst_n();
    do_roll(6, 1);
    chk("abort.point_set", int'(if_def.point_o), 6);
    rst_i = 1'b1;
    rb    = 1'b1;
    tick();
    chk("abort.roll",   int'(if_def.roll_o),        0);
    chk("abort.point",  int'(if_def.point_o),       0);
    chk("abort.pvalid", int'(if_def.point_valid_o), 0);
    chk("abort.rolls",  int'(if_def.roll_cnt_o),    0);
    chk("abort.stats",  int'(if_def.wins_o) + int'(if_def.losses_o), 0);
    rst_i = 1'b0;
    rb    = 1'b0;
    tick();
    do_roll(7, 2);
    chk("abort.first_roll_again", int'(if_def.win_o), 1);
    $display("txn abort: win=%0d wins=%0d", if_def.win_o, if_def.wins_o);
    new_game();

    // New-game request during a roll drops roll_o on the next edge
    rb = 1'b1;
    tick();
    chk("abort_roll.roll_hi", int'(if_def.roll_o), 1);
    rst_i = 1'b1;
    tick();
    chk("abort_roll.roll_lo", int'(if_def.roll_o), 0);
    rst_i = 1'b0;
    rb    = 1'b0;
    tick();
    chk("abort_roll.idle", int'(if_def.roll_o), 0);
    $display("txn abort_roll: roll=%0d", if_def.roll_o);

    // Asynchronous reset in the middle of a point roll
    do_roll(6, 1);
    rb = 1'b1;
    tick();
    chk("async.roll_hi", int'(if_def.roll_o),        1);
    chk("async.pvalid",  int'(if_def.point_valid_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async.roll",   int'(if_def.roll_o),        0);
    chk("async.point",  int'(if_def.point_o),       0);
    chk("async.pvalid", int'(if_def.point_valid_o), 0);
    chk("async.rolls",  int'(if_def.roll_cnt_o),    0);
    chk("async.wins",   int'(if_def.wins_o),        0);
    $display("txn async_reset: roll=%0d point=%0d wins=%0d", if_def.roll_o, if_def.point_o, if_def.wins_o);
    rb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Win counter saturation with a 2-bit counter
    pulse_rst_n();
    for (int k = 0; k < 4; k++) begin
      do_roll(7, 1);
      chk($sformatf("sat.win%0d", k),  int'(if_sat.win_o),  1);
      chk($sformatf("sat.wins%0d", k), int'(if_sat.wins_o), (k < 3) ? k + 1 : 3);
      $display("txn sat%0d: wins=%0d", k, if_sat.wins_o);
      new_game();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dice_game_gen.md
Name: dice_game_gen

Overview:
- Parametrised next-generation craps controller: N-faced dice, configurable roll limit, point tracking and win/loss statistics.
- Drives the external dice counter via roll_o. Samples the two-dice sum on sum_i after the roll button is released.
- Sits alongside the dice counter and stimulus generator in the game subsystem.

Parameters:
- FACES, 6, faces per die. Legal range 3..15.
- SUM_W, 4, width of sum and point. Must hold 2*FACES.
- MAX_ROLLS, 0, roll limit per game. 0 = unlimited.
- CNT_W, 8, width of the roll, win and loss counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Rb_i  input  1  roll button. Level; high = rolling.
- Reset_i  input  1  new-game request. Level, sampled on clk.
- sum_i  input  SUM_W  two-dice sum from dice counter. Valid while roll_o=0.
- roll_o  output  1  dice counter enable.
- win_o  output  1  game won.
- lose_o  output  1  game lost.
- point_o  output  SUM_W  stored point value. 0 when no point is held.
- point_valid_o  output  1  a point is established.
- roll_cnt_o  output  CNT_W  accepted rolls in the current game.
- wins_o  output  CNT_W  total games won, saturating.
- losses_o  output  CNT_W  total games lost, saturating.

Behaviour:
- Derived constants:
  - NAT1 = FACES+1 (7 when FACES=6).
  - NAT2 = 2*FACES-1 (11).
  - CRAPS set = {2, 3, 2*FACES}.
  - Legal sum range = 2..2*FACES.
- States: WAIT_FIRST, ROLL_FIRST, EVAL_FIRST, WAIT_NEXT, ROLL_NEXT, EVAL_NEXT, WIN, LOSE.
- Outputs are Moore and registered. All outputs change only on clk edges, except at reset.
- Reset (rst_n=0, asynchronous):
  - State goes to WAIT_FIRST.
  - All outputs 0. point and all counters cleared.
  - Takes effect mid-roll or mid-game with no residual state.
- WAIT_FIRST / WAIT_NEXT:
  - Rb_i=1 → ROLL_FIRST / ROLL_NEXT next cycle.
- ROLL_x:
  - roll_o=1.
  - Stays while Rb_i=1.
  - Rb_i=0 → EVAL_x next cycle. roll_o drops on that same edge.
- EVAL_x:
  - Samples sum_i once.
  - Out-of-range sum (<2 or >2*FACES): roll rejected. roll_cnt unchanged. Return to the matching WAIT_x.
  - Otherwise roll_cnt increments, saturating at all-ones.
- EVAL_FIRST with a legal sum:
  - sum ∈ {NAT1, NAT2} → WIN.
  - sum ∈ CRAPS → LOSE.
  - Else: point ← sum, point_valid_o=1, → WAIT_NEXT.
- EVAL_NEXT with a legal sum:
  - sum == point → WIN.
  - Else if sum == NAT1 → LOSE.
  - Else if MAX_ROLLS≠0 and the updated roll_cnt == MAX_ROLLS → LOSE (roll limit).
  - Else → WAIT_NEXT.
- Decision latency: win_o/lose_o assert exactly 1 cycle after the EVAL cycle. That is 2 cycles after the falling edge of Rb_i is sampled.
- WIN / LOSE:
  - win_o or lose_o held high. Rb_i ignored.
  - wins_o / losses_o increment exactly once, on entry. Both saturate at 2^CNT_W-1.
  - Reset_i=1 → WAIT_FIRST next cycle: win/lose cleared, point_o=0, point_valid_o=0, roll_cnt_o=0. Statistics counters kept.
- Reset_i=1 in any other state:
  - Aborts the game → WAIT_FIRST, same clearing as above.
  - No statistics change.
  - Takes priority over Rb_i in the same cycle. roll_o drops next cycle.
- Point of NAT1 is impossible: NAT1 always resolves on the first roll.
- win_o and lose_o are never both high.

Test Plan:
- Defaults. Hold Rb_i 3 cycles, release, sum_i=7 → roll_o high 3 cycles; win_o=1 two cycles after release; wins_o=1, roll_cnt_o=1.
- First roll 12, then Reset_i pulse → lose_o=1, losses_o=1. After Reset_i: lose_o=0, roll_cnt_o=0, losses_o still 1.
- Rolls 4, 5, 8, 4 → point_o=4, point_valid_o=1 after first roll; win_o after fourth roll; roll_cnt_o=4.
- Rolls 6 then 7 → lose_o=1, point_o=6 retained until Reset_i.
- MAX_ROLLS=3, rolls 5, 8, 9 → lose_o=1 after third roll. Same bench with a sum_i=0 roll inserted: roll rejected, roll_cnt_o unchanged, limit hit one roll later.
- Abort and reset cases:
  - Reset_i and Rb_i both high in WAIT_NEXT → WAIT_FIRST, point cleared, no stats change.
  - rst_n low mid-ROLL_NEXT → all outputs 0 immediately, without waiting for a clock edge.
  - CNT_W=2, four wins → wins_o saturates at 3.
